// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin sharing of one two-stage multiplier among N_REQ requesters
module fmul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      req_order,
  input  logic [32*N_REQ-1:0]   req_rs1,
  input  logic [32*N_REQ-1:0]   req_rs2,
  output logic [N_REQ-1:0]      req_accepted,
  output logic [N_REQ-1:0]      resp_done,
  output logic [31:0]           resp_rd,
  output logic                  err_timeout,
  output logic                  u_order,
  output logic [31:0]           u_rs1,
  output logic [31:0]           u_rs2,
  input  logic                  u_accepted,
  input  logic                  u_done,
  input  logic [31:0]           u_rd
);
  localparam int GW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [GW-1:0] gnt, gnt_n, ptr, ptr_n, gnt_inc;
  logic [7:0] tcnt, tcnt_n;
  logic err_n;
  logic [N_REQ-1:0] done_n, others;
  logic [31:0] rd_n;
  function automatic logic [GW-1:0] pick(input logic [N_REQ-1:0] r, input logic [GW-1:0] p);
    logic [GW-1:0] i;
    pick = p;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      i = GW'((int'(p) + k) % N_REQ);
      if (r[i]) pick = i;
    end
  endfunction
  assign gnt_inc = (gnt == GW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
  assign others = req_order & ~(N_REQ'(1) << gnt);
  assign u_order = state == ISSUE;
  assign u_rs1 = u_order ? req_rs1[32*gnt +: 32] : '0;
  assign u_rs2 = u_order ? req_rs2[32*gnt +: 32] : '0;
  assign req_accepted = (u_order && u_accepted) ? N_REQ'(1) << gnt : '0;
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    ptr_n = ptr;
    tcnt_n = tcnt;
    err_n = err_timeout;
    done_n = '0;
    rd_n = resp_rd;
    case (state)
      IDLE: if (|req_order) begin
        gnt_n = pick(req_order, ptr);
        state_n = ISSUE;
      end
      ISSUE: if (u_accepted) begin
        tcnt_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        tcnt_n = (&tcnt) ? tcnt : tcnt + 8'd1;
        if (u_done) begin
          rd_n = u_rd;
          done_n = N_REQ'(1) << gnt;
          ptr_n = gnt_inc;
          state_n = |others ? ISSUE : IDLE;
          gnt_n = |others ? pick(others, gnt_inc) : gnt;
        end else if (tcnt == 8'(TIMEOUT - 2)) begin
          err_n = 1'b1;
          ptr_n = gnt_inc;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      gnt <= '0;
      ptr <= '0;
      tcnt <= '0;
      err_timeout <= 1'b0;
      resp_done <= '0;
      resp_rd <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      ptr <= ptr_n;
      tcnt <= tcnt_n;
      err_timeout <= err_n;
      resp_done <= done_n;
      resp_rd <= rd_n;
    end
  end
endmodule
